// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, IF/ID entry
// layout and HALT opcode decode (used when FETCH_HALT_DETECT_EN is defined).
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HOLD    = 2'd2,
        ST_HALT    = 2'd3
    } fetch_state_t;

    localparam logic [4:0]  OPC_HALT          = 5'b00000;
    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;
    localparam logic [15:0] PC_INC            = 16'd2;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] next_pc;
        logic [15:0] instr;
    } ifid_entry_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == OPC_HALT;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load, hold and flush controls; also used as the
// holding register that parks a word fetched while decode is stalled.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [15:0] NOP_WORD = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        hold,
    input  logic        flush,
    input  ifid_entry_t d,
    output ifid_entry_t q,
    output logic        valid
);

    ifid_entry_t q_reg;
    logic        valid_reg;

    // Dropping an entry (flush, or consumed with nothing new) also restores the NOP
    // word so the instruction bus never shows stale data while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg     <= '{pc: 16'h0000, next_pc: 16'h0000, instr: NOP_WORD};
            valid_reg <= 1'b0;
        end else if (flush) begin
            q_reg.instr <= NOP_WORD;
            valid_reg   <= 1'b0;
        end else if (load) begin
            q_reg     <= d;
            valid_reg <= 1'b1;
        end else if (!hold) begin
            q_reg.instr <= NOP_WORD;
            valid_reg   <= 1'b0;
        end
    end

    assign q     = q_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, IF/ID register,
// stall absorption and redirects. HALT detection enabled by FETCH_HALT_DETECT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        err,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic [15:0] PC_out,
    output logic [15:0] next_PC_out,
    output logic [15:0] instruction,
    output logic        valid,
    output logic        halted
);

    fetch_state_t state_reg;
    logic [15:0]  pc_reg;
    logic [15:0]  req_addr_reg;
    logic         err_reg;
    logic         halted_reg;

    logic [15:0]  pc_inc;
    ifid_entry_t  fetched, ifid_d, ifid_q, hold_q;
    logic         ifid_valid, hold_valid;
    logic         slot_free, fetch_done, hold_release;
    logic         ifid_load, hold_load, hold_keep, halt_load;

    assign pc_inc       = pc_reg + PC_INC;
    assign fetched      = '{pc: pc_reg, next_pc: pc_inc, instr: imem_rdata};
    assign slot_free    = !ifid_valid || !stall;
    assign fetch_done   = (state_reg == ST_FETCH) && imem_done;
    assign hold_release = (state_reg == ST_HOLD) && !stall && hold_valid;
    assign ifid_load    = (fetch_done && slot_free) || hold_release;
    assign hold_load    = fetch_done && !slot_free;
    assign hold_keep    = (state_reg == ST_HOLD) && stall;
    assign ifid_d       = hold_release ? hold_q : fetched;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_load = ifid_load && is_halt(ifid_d.instr);
`else
    assign halt_load = 1'b0;
`endif

    ifid_reg #(.NOP_WORD(NOP_INSTR)) u_ifid (
        .clk   (clk),
        .rst   (rst),
        .load  (ifid_load),
        .hold  (stall),
        .flush (redirect),
        .d     (ifid_d),
        .q     (ifid_q),
        .valid (ifid_valid)
    );

    ifid_reg #(.NOP_WORD(NOP_INSTR)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (hold_load),
        .hold  (hold_keep),
        .flush (redirect),
        .d     (fetched),
        .q     (hold_q),
        .valid (hold_valid)
    );

    // req_addr_reg remembers the address of the in-flight request so DISCARD can keep
    // imem_addr stable while pc already points at the redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_FETCH;
            pc_reg       <= RESET_PC;
            req_addr_reg <= RESET_PC;
            err_reg      <= 1'b0;
            halted_reg   <= 1'b0;
        end else begin
            if (state_reg == ST_FETCH) begin
                req_addr_reg <= pc_reg;
            end
            if (redirect) begin
                pc_reg     <= {redirect_pc[15:1], 1'b0};
                halted_reg <= 1'b0;
                if (redirect_pc[0]) begin
                    err_reg <= 1'b1;
                end
                state_reg  <= (imem_rd && !imem_done) ? ST_DISCARD : ST_FETCH;
            end else begin
                case (state_reg)
                    ST_FETCH: begin
                        if (imem_done) begin
                            pc_reg <= pc_inc;
                            if (!slot_free) begin
                                state_reg <= ST_HOLD;
                            end else if (halt_load) begin
                                state_reg  <= ST_HALT;
                                halted_reg <= 1'b1;
                            end
                        end
                    end
                    ST_DISCARD: begin
                        if (imem_done) begin
                            state_reg <= ST_FETCH;
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            if (halt_load) begin
                                state_reg  <= ST_HALT;
                                halted_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_FETCH;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_rd     = !rst && ((state_reg == ST_FETCH) || (state_reg == ST_DISCARD));
    assign imem_addr   = (state_reg == ST_DISCARD) ? req_addr_reg : pc_reg;
    assign err         = err_reg;
    assign halted      = halted_reg;
    assign PC_out      = ifid_q.pc;
    assign next_PC_out = ifid_q.next_pc;
    assign instruction = ifid_q.instr;
    assign valid       = ifid_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a wait-state memory model feeds the DUT and every
// consumed IF/ID entry is popped against the expected PC/word queue.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err, imem_rd, imem_done;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic        valid, halted;
    logic [15:0] imem_addr, imem_rdata, PC_out, next_PC_out, instruction;
    logic [15:0] redirect_pc = 16'h0000;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .err         (err),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_rdata  (imem_rdata),
        .imem_done   (imem_done),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .PC_out      (PC_out),
        .next_PC_out (next_PC_out),
        .instruction (instruction),
        .valid       (valid),
        .halted      (halted)
    );

    // Memory model: done fires mem_wait cycles after a request (re)starts.
    logic [15:0] mem [0:127];
    int mem_wait = 0;
    int wait_cnt = 0;

    assign imem_done  = imem_rd && (wait_cnt == mem_wait);
    assign imem_rdata = imem_done ? mem[imem_addr[7:1]] : 16'hDEAD;

    always @(posedge clk) begin
        if (!imem_rd || imem_done) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic push_exp(input logic [15:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem[pc[7:1]];
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [15:0] en;
        if (rst === 1'b0 && valid === 1'b1 && stall === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: consumed pc=%h instr=%h, required none", PC_out, instruction);
            end else begin
                e  = exp_q.pop_front();
                en = e.pc + 16'd2;
                $display("consume pc=%h next=%h instr=%h", PC_out, next_PC_out, instruction);
                if (PC_out !== e.pc || next_PC_out !== en || instruction !== e.instr) begin
                    n_fail++;
                    $display("FAIL sb_entry: got pc=%h next=%h instr=%h, required pc=%h next=%h instr=%h",
                             PC_out, next_PC_out, instruction, e.pc, en, e.instr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int w);
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; mem_wait = w;
        step();
        step();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic drain(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (exp_q.size() == 0) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_wait = 0;
        step();
        step();
        @(negedge clk);
        n_checks++;
        if (imem_rd !== 1'b0 || valid !== 1'b0 || err !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rd=%b valid=%b err=%b halted=%b, required 0 0 0 0", imem_rd, valid, err, halted);
        end
        n_checks++;
        if (instruction !== 16'h0800 || PC_out !== 16'h0000 || next_PC_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_ifid: got instr=%h pc=%h next=%h, required 0800 0000 0000", instruction, PC_out, next_PC_out);
        end
        step();
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0000 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_req: got rd=%b addr=%h valid=%b, required 1 0000 0", imem_rd, imem_addr, valid);
        end
        step();
        rst = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_zero_wait();
        bit ok;
        logic [15:0] ep;
        do_reset(0);
        for (int i = 0; i < 8; i++) push_exp(16'(2 * i));
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || imem_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL zw_cycle1: got valid=%b rd=%b, required 0 1", valid, imem_rd);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            ep = 16'(2 * c);
            n_checks++;
            if (valid !== 1'b1 || PC_out !== ep || next_PC_out !== ep + 16'd2) begin
                n_fail++;
                $display("FAIL zw_stream: got valid=%b pc=%h next=%h, required 1 %h %h", valid, PC_out, next_PC_out, ep, ep + 16'd2);
            end
        end
        step();
        drain(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL zw_drain: %0d entries left, required 0", exp_q.size());
        end
        rst = 1'b1;
        $display("test_zero_wait done");
    endtask

    task automatic test_wait3();
        bit ok;
        do_reset(3);
        for (int i = 0; i < 3; i++) push_exp(16'(2 * i));
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (imem_rd !== 1'b1 || imem_addr !== 16'h0000 || valid !== 1'b0) begin
                n_fail++;
                $display("FAIL w3_wait_c%0d: got rd=%b addr=%h valid=%b, required 1 0000 0", c, imem_rd, imem_addr, valid);
            end
            step();
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || PC_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL w3_first_valid: got valid=%b pc=%h, required 1 0000", valid, PC_out);
        end
        step();
        drain(40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL w3_drain: %0d entries left, required 0", exp_q.size());
        end
        rst = 1'b1;
        $display("test_wait3 done");
    endtask

    task automatic test_stall();
        bit ok;
        do_reset(0);
        for (int i = 0; i < 6; i++) push_exp(16'(2 * i));
        step();
        stall = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || PC_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL st_entry: got valid=%b pc=%h, required 1 0000", valid, PC_out);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            @(negedge clk);
            n_checks++;
            if (imem_rd !== 1'b0 || valid !== 1'b1 || PC_out !== 16'h0000 || instruction !== mem[0]) begin
                n_fail++;
                $display("FAIL st_hold: got rd=%b valid=%b pc=%h instr=%h, required 0 1 0000 %h", imem_rd, valid, PC_out, instruction, mem[0]);
            end
        end
        step();
        stall = 1'b0;
        step();
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || PC_out !== 16'h0002 || imem_rd !== 1'b1 || imem_addr !== 16'h0004) begin
            n_fail++;
            $display("FAIL st_release: got valid=%b pc=%h rd=%b addr=%h, required 1 0002 1 0004", valid, PC_out, imem_rd, imem_addr);
        end
        step();
        drain(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL st_drain: %0d entries left, required 0", exp_q.size());
        end
        rst = 1'b1;
        $display("test_stall done");
    endtask

    task automatic test_redirect();
        bit ok;
        bit found;
        do_reset(2);
        push_exp(16'h0000); push_exp(16'h0002); push_exp(16'h0004);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_rd === 1'b1 && imem_addr === 16'h0006) begin
                found = 1'b1;
                break;
            end
            step();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rd_find_req: request to 0006 not seen, required within 60 cycles");
        end
        step();
        redirect = 1'b1; redirect_pc = 16'h0040;
        push_exp(16'h0040); push_exp(16'h0042);
        step();
        redirect = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0006 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_discard: got rd=%b addr=%h valid=%b, required 1 0006 0", imem_rd, imem_addr, valid);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0040 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_refetch: got rd=%b addr=%h valid=%b, required 1 0040 0", imem_rd, imem_addr, valid);
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            if (valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found || PC_out !== 16'h0040) begin
            n_fail++;
            $display("FAIL rd_target: got valid=%b pc=%h, required 1 0040", valid, PC_out);
        end
        step();
        drain(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rd_drain: %0d entries left, required 0", exp_q.size());
        end
        rst = 1'b1;
        $display("test_redirect done");
    endtask

    task automatic test_misaligned();
        bit ok;
        do_reset(0);
        push_exp(16'h0000); push_exp(16'h0002);
        step();
        step();
        redirect = 1'b1; redirect_pc = 16'h0041;
        push_exp(16'h0040); push_exp(16'h0042); push_exp(16'h0044);
        step();
        redirect = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || valid !== 1'b0 || imem_addr !== 16'h0040) begin
            n_fail++;
            $display("FAIL ma_redirect: got err=%b valid=%b addr=%h, required 1 0 0040", err, valid, imem_addr);
        end
        step();
        drain(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ma_drain: %0d entries left, required 0", exp_q.size());
        end
        stall = 1'b1;
        repeat (3) step();
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL ma_sticky: got err=%b, required 1", err);
        end
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL ma_clear: got err=%b, required 0", err);
        end
        stall = 1'b0;
        $display("test_misaligned done");
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset(0);
        push_exp(16'h0000);
        step();
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        push_exp(16'hFFFE); push_exp(16'h0000); push_exp(16'h0002);
        step();
        redirect = 1'b0;
        step();
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || PC_out !== 16'hFFFE || next_PC_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL wr_top: got valid=%b pc=%h next=%h, required 1 fffe 0000", valid, PC_out, next_PC_out);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || PC_out !== 16'h0000 || next_PC_out !== 16'h0002) begin
            n_fail++;
            $display("FAIL wr_after: got valid=%b pc=%h next=%h, required 1 0000 0002", valid, PC_out, next_PC_out);
        end
        step();
        drain(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wr_drain: %0d entries left, required 0", exp_q.size());
        end
        rst = 1'b1;
        $display("test_wrap done");
    endtask

    task automatic test_halt();
        bit ok;
        logic [15:0] saved;
        saved  = mem[4];
        mem[4] = 16'h0000;
        do_reset(0);
`ifdef FETCH_HALT_DETECT_EN
        for (int i = 0; i < 5; i++) push_exp(16'(2 * i));
        drain(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ht_drain: %0d entries left, required 0", exp_q.size());
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (halted !== 1'b1 || imem_rd !== 1'b0) begin
                n_fail++;
                $display("FAIL ht_halted: got halted=%b rd=%b, required 1 0", halted, imem_rd);
            end
            step();
        end
        redirect = 1'b1; redirect_pc = 16'h0010;
        push_exp(16'h0010); push_exp(16'h0012);
        step();
        redirect = 1'b0;
        @(negedge clk);
        n_checks++;
        if (halted !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 16'h0010) begin
            n_fail++;
            $display("FAIL ht_resume: got halted=%b rd=%b addr=%h, required 0 1 0010", halted, imem_rd, imem_addr);
        end
        step();
        drain(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ht_resume_drain: %0d entries left, required 0", exp_q.size());
        end
`else
        for (int i = 0; i < 7; i++) push_exp(16'(2 * i));
        drain(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ht_drain: %0d entries left, required 0", exp_q.size());
        end
        stall = 1'b1;
        @(negedge clk);
        n_checks++;
        if (halted !== 1'b0 || valid !== 1'b1 || PC_out !== 16'h000E) begin
            n_fail++;
            $display("FAIL ht_continue: got halted=%b valid=%b pc=%h, required 0 1 000e", halted, valid, PC_out);
        end
        step();
`endif
        rst    = 1'b1;
        stall  = 1'b0;
        mem[4] = saved;
        $display("test_halt done");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h4001 + 16'(i);
        test_reset();
        test_zero_wait();
        test_wait3();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_halt();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage feeding the decode stage. Owns the PC register, drives a variable-latency instruction-memory request/done handshake, and holds the IF/ID pipeline register (`PC_out`, `next_PC_out`, `instruction`, `valid`) that decode consumes. It also absorbs decode back-pressure and handles branch/jump redirects from execute.

## Interface
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `NOP_INSTR`, 16'h0800: value driven on `instruction` whenever `valid`=0.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `err`  out  1  sticky misaligned-redirect error.
- `imem_addr`  out  16  fetch address.
- `imem_rd`  out  1  fetch request.
- `imem_rdata`  in  16  instruction word; valid only when `imem_done`=1.
- `imem_done`  in  1  one-cycle completion pulse.
- `redirect`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  16  redirect target.
- `stall`  in  1  decode cannot accept; hold IF/ID contents.
- `PC_out`  out  16  address of the instruction in IF/ID.
- `next_PC_out`  out  16  `PC_out`+2.
- `instruction`  out  16  fetched word.
- `valid`  out  1  IF/ID holds a live instruction.
- `halted`  out  1  fetch stopped on HALT (see Configuration).

## Operation
- States: FETCH, DISCARD, HOLD, HALT. Reset enters FETCH.
- FETCH:
  - `imem_rd`=1 and `imem_addr`=pc. Both are held stable until `imem_done`.
  - `imem_done` may rise in the same cycle `imem_rd` first rises (zero-wait) or in any later cycle.
- On `imem_done` in FETCH:
  - Slot free (`!valid || !stall`): the word loads into IF/ID, `PC_out`=pc, `next_PC_out`=pc+2, then pc←pc+2 and the state stays FETCH.
  - Slot busy: the word, pc and pc+2 go to a holding register, pc←pc+2, state→HOLD.
- HOLD:
  - `imem_rd`=0.
  - The first cycle with `stall`=0 transfers the holding register into IF/ID, then the state→FETCH.
- IF/ID consumption: an entry is consumed in any cycle with `valid`=1 and `stall`=0. With no new word arriving, `valid`←0.
- Redirect (highest priority; overrides `stall`, done and HALT):
  - pc←`redirect_pc`, `valid`←0, holding register dropped.
  - Request outstanding and `imem_done`=0 that cycle: state→DISCARD. DISCARD keeps `imem_rd`/`imem_addr` stable, drops the data on `imem_done`, then returns to FETCH at the new pc.
  - Otherwise: state→FETCH, and any word completing in the redirect cycle is dropped.
- Redirect arriving during DISCARD: pc is updated and the state stays DISCARD.
- Misaligned redirect (`redirect_pc[0]`=1): `err`←1 and stays 1 until reset; pc←{`redirect_pc[15:1]`,0}.
- pc+2 wraps modulo 2^16 (16'hFFFE→16'h0000).
- Reset values: pc=`RESET_PC`, `valid`=0, `instruction`=`NOP_INSTR`, `PC_out`=0, `next_PC_out`=0, `err`=0, `halted`=0. `imem_rd`=0 in every cycle `rst` is high.
- Reset mid-request: the outstanding transaction is abandoned. The memory model must tolerate a dropped request.

## Timing
- Zero-wait memory: request in cycle t, `valid`=1 at t+1. Throughput is one instruction per cycle while `stall`=0.
- N-wait memory: `imem_done` in cycle t+N, IF/ID valid at t+N+1.
- Redirect in cycle t: `valid`=0 at t+1. The new fetch request starts at t+1 (if no request is outstanding) or in the cycle after the discarded `imem_done`.
- HOLD release: `stall` falls in cycle t, IF/ID loads at t+1, next request at t+1.
- First request after reset: the cycle after `rst` falls.

## Configuration
- `FETCH_HALT_DETECT_EN` defined:
  - When a word with opcode [15:11]=5'b00000 loads into IF/ID, the state→HALT.
  - HALT: `imem_rd`=0, pc frozen, `halted`=1.
  - A redirect exits HALT to FETCH and clears `halted`.
- Undefined: HALT words are fetched like any other instruction, `halted` is tied 0, and the HALT state is unreachable.

## Structure
- Shared package/include `fetch_pkg`: state encoding, `OPC_HALT`=5'b00000, `NOP_INSTR` default, `PC_INC`=2.
- One sub-module: `ifid_reg`, the IF/ID pipeline register. It has load, hold (`stall`) and flush (redirect) controls, and reset values as above. The same register shape is reused by the holding register.

## Test plan
- Zero-wait memory, words 16'h4001, 16'h4002, 16'h4003 at 0, 2, 4, `stall`=0 → `valid` from cycle 2 after reset; `PC_out` 0, 2, 4 on consecutive cycles; `next_PC_out` 2, 4, 6.
- 3-wait memory → each word appears 4 cycles after its request rises; `imem_addr` stays stable across the wait cycles.
- `stall` high for 3 cycles with a word completing → IF/ID unchanged, HOLD entered, `imem_rd`=0; after `stall` falls, next word loads with the correct PC and no loss or duplication.
- Redirect to 16'h0040 while a 2-wait request to 16'h0006 is outstanding → DISCARD, the 16'h0006 data is dropped, next `valid` shows `PC_out`=16'h0040, and `valid`=0 in between.
- Redirect to 16'h0041 → `err`=1 and stays 1; fetch proceeds at 16'h0040; `rst` clears `err`.
- With `FETCH_HALT_DETECT_EN`, word 16'h0000 at 16'h0008 → `halted`=1 and no further `imem_rd`; a redirect to 16'h0010 resumes fetch. Without the macro, fetching continues at 16'h000A.
